// File: rtl/sized_dmem_pkg.sv
// sized_dmem_pkg: shared types and helpers for sized_data_memory.
//   - access size encodings SZ_B/SZ_H/SZ_W/SZ_D
//   - FSM state enum (IDLE/WAIT/RESP)
//   - captured request payload struct
//   - size_bytes(): byte count for a size; is_misaligned(): alignment test
package sized_dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields held for the whole access (address kept separately, its width is a parameter).
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [63:0] wdata;
    } req_t;

    // Number of bytes touched by an access of the given size: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'(4'd1 << size);
    endfunction

    // True when addr[size-1:0] is non-zero for half/word/double accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lsb);
        case (size)
            SZ_H:    return lsb[0];
            SZ_W:    return |lsb[1:0];
            SZ_D:    return |lsb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sized_data_memory_load_extend.sv
// load_extend: combinational sign/zero extension of gathered load bytes.
// Ports:
//   raw_data     in  64 : bytes gathered little-endian from the access index
//   size         in  2  : access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_unsigned  in  1  : 1 = zero-extend, 0 = sign-extend (ignored for doubles)
//   ext_data_c   out 64 : extended load result
module load_extend
    import sized_dmem_pkg::*;
(
    input  logic [63:0] raw_data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] ext_data_c
);

    // Select the low bytes of the access and fill the upper bits.
    always_comb begin
        ext_data_c = raw_data;
        case (size)
            SZ_B: ext_data_c = is_unsigned ? {56'd0, raw_data[7:0]}
                                           : {{56{raw_data[7]}}, raw_data[7:0]};
            SZ_H: ext_data_c = is_unsigned ? {48'd0, raw_data[15:0]}
                                           : {{48{raw_data[15]}}, raw_data[15:0]};
            SZ_W: ext_data_c = is_unsigned ? {32'd0, raw_data[31:0]}
                                           : {{32{raw_data[31]}}, raw_data[31:0]};
            default: ext_data_c = raw_data;
        endcase
    end

endmodule

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressed data memory with a valid/ready request
// port, a single-cycle response pulse and a fixed access latency.
// Stores write only the addressed bytes; loads are sign/zero extended.
// Optional feature macro: SIZED_DMEM_MISALIGN_TRAP_EN (reject misaligned
// half/word/double accesses with resp_err).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_write               : 1 = store, 0 = load
//   req_size                : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned            : load zero-extends when 1
//   req_addr                : byte address (low log2(DEPTH) bits used)
//   req_wdata               : store data, LSB aligned
//   resp_valid              : one-cycle response pulse
//   resp_rdata              : extended load data (0 for stores/errors)
//   resp_err                : access rejected
module sized_data_memory
    import sized_dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    req_t               cap;
    logic [IDX_W-1:0]   cap_idx;
    logic [7:0]         mem [DEPTH];

    logic               accept_c;
    logic               finish_c;
    logic               err_c;
    logic [63:0]        raw_c;
    logic [63:0]        ext_c;
    logic               ready_nxt;
    logic               valid_nxt;
    logic [63:0]        rdata_nxt;
    logic               err_nxt;

    // Address bits above the byte index only select an alias of the array.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];

    assign accept_c = (state == IDLE) && req_valid;
    assign finish_c = (state == WAIT) && (cnt == '0);

`ifdef SIZED_DMEM_MISALIGN_TRAP_EN
    assign err_c = is_misaligned(cap.size, cap_idx[2:0]);
`else
    assign err_c = 1'b0;
`endif

    // Gather 8 bytes little-endian from the captured index, wrapping modulo DEPTH.
    always_comb begin
        raw_c = '0;
        for (int k = 0; k < 8; k++) begin
            raw_c[8*k +: 8] = mem[IDX_W'(cap_idx + IDX_W'(k))];
        end
    end

    load_extend u_load_extend (
        .raw_data    (raw_c),
        .size        (cap.size),
        .is_unsigned (cap.is_unsigned),
        .ext_data_c  (ext_c)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the response is built on the WAIT->RESP edge.
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        valid_nxt = (state_nxt == RESP);
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        if (finish_c) begin
            err_nxt   = err_c;
            rdata_nxt = (cap.write || err_c) ? 64'd0 : ext_c;
        end
    end

    // State, counter, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap        <= '0;
            cap_idx    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_ready  <= ready_nxt;
            resp_valid <= valid_nxt;
            resp_rdata <= rdata_nxt;
            resp_err   <= err_nxt;
            if (accept_c) begin
                cnt             <= CNT_W'(LATENCY - 1);
                cap.write       <= req_write;
                cap.size        <= req_size;
                cap.is_unsigned <= req_unsigned;
                cap.wdata       <= req_wdata;
                cap_idx         <= req_addr[IDX_W-1:0];
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Byte array: cleared on reset, store commits on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (finish_c && cap.write && !err_c) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < size_bytes(cap.size)) begin
                    mem[IDX_W'(cap_idx + IDX_W'(k))] <= cap.wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
